// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// sar_pkg : shared types and helpers for the SAR ADC scan controller
// Rev 1.0
// ============================================================================
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EMIT   = 3'd4,
    ST_PARK   = 3'd5
  } state_t;

  // Core latency from start to the first eoc, and between successive eocs
  localparam int CORE_CONV_CYCLES = 7;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_rr_pick.sv
`default_nettype none
// ============================================================================
// sar_rr_pick : round-robin finder for the next enabled channel after ptr
// Rev 1.0
// ============================================================================
module sar_rr_pick
  import sar_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]          mask,
  input  logic [clog2(NCH)-1:0]   ptr,
  input  logic                    inclusive,
  output logic [clog2(NCH)-1:0]   next,
  output logic                    any
);

  localparam int c_cw = clog2(NCH);

  logic [c_cw-1:0] w_idx;

  // Scan from the farthest offset down so the nearest enabled channel wins
  always_comb begin
    next  = '0;
    w_idx = '0;
    any   = |mask;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = c_cw'((int'(ptr) + k + (inclusive ? 0 : 1)) % NCH);
      if (mask[w_idx]) next = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// sar_scan_ctrl : round-robin SAR ADC channel scanner with oversampling sum
// Rev 1.0
// ============================================================================
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int RES      = 5,
  parameter int OSR_LOG2 = 2,
  parameter int SETTLE   = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NCH-1:0]            ch_mask,
  input  logic                      adc_eoc,
  input  logic [RES-1:0]            adc_data,
  output logic                      adc_start,
  output logic                      adc_reset,
  output logic [clog2(NCH)-1:0]     mux_sel,
  output logic [RES+OSR_LOG2-1:0]   result,
  output logic [clog2(NCH)-1:0]     result_ch,
  output logic                      result_valid,
  output logic                      fault,
  output logic                      busy
);

  localparam int c_cw    = clog2(NCH);
  localparam int c_aw    = RES + OSR_LOG2;
  localparam int c_nconv = 1 << OSR_LOG2;
  localparam int c_kw    = OSR_LOG2 + 1;
  localparam int c_sw    = clog2(SETTLE + 1);
  localparam int c_tw    = clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [c_cw-1:0]   r_ptr;
  logic              r_first;
  logic [c_cw-1:0]   w_pick;
  logic              w_any;
  logic [c_sw-1:0]   r_set;
  logic [c_tw-1:0]   r_tmo;
  logic [c_kw-1:0]   r_cnt;
  logic [c_aw-1:0]   r_acc;

  sar_rr_pick #(.NCH(NCH)) u_pick (
    .mask      (ch_mask),
    .ptr       (r_ptr),
    .inclusive (r_first),
    .next      (w_pick),
    .any       (w_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (enable && w_any) w_next = ST_SETTLE;
      ST_SETTLE: begin
        if (!enable)                          w_next = ST_PARK;
        else if (r_set == c_sw'(SETTLE - 1))  w_next = ST_START;
      end
      ST_START:  w_next = enable ? ST_WAIT : ST_PARK;
      ST_WAIT: begin
        // An eoc in the expiry cycle wins over the timeout
        if (!enable)                             w_next = ST_PARK;
        else if (adc_eoc) begin
          if (r_cnt == c_kw'(c_nconv - 1))       w_next = ST_EMIT;
        end else if (r_tmo == c_tw'(TIMEOUT - 1)) w_next = ST_PARK;
      end
      ST_EMIT:   if (result_valid) w_next = ST_PARK;
      ST_PARK:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_start = (r_state == ST_START);
    adc_reset = reset || (r_state == ST_PARK);
    busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_first      <= 1'b1;
      r_set        <= '0;
      r_tmo        <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      mux_sel      <= '0;
      result       <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable && w_any) begin
            mux_sel <= w_pick;
            r_first <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_set   <= '0;
          end
        end
        ST_SETTLE: r_set <= r_set + c_sw'(1);
        ST_START:  r_tmo <= c_tw'(1);
        ST_WAIT: begin
          if (enable) begin
            if (adc_eoc) begin
              r_acc <= r_acc + c_aw'(adc_data);
              r_cnt <= r_cnt + c_kw'(1);
              r_tmo <= c_tw'(1);
            end else if (r_tmo == c_tw'(TIMEOUT - 1)) begin
              fault <= 1'b1;
            end else begin
              r_tmo <= r_tmo + c_tw'(1);
            end
          end
        end
        // EMIT spans two cycles: capture, then the valid pulse
        ST_EMIT: begin
          if (!result_valid) begin
            result       <= r_acc;
            result_ch    <= mux_sel;
            result_valid <= 1'b1;
          end else begin
            result_valid <= 1'b0;
          end
        end
        ST_PARK:   r_ptr <= mux_sel;
        default:   r_ptr <= r_ptr;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sar_scan_ctrl : randomized bench with a timeline-based scan model
// Rev 1.0
// ============================================================================
module tb_sar_scan_ctrl;
  import sar_pkg::*;

  localparam int NCH   = 4;
  localparam int S     = 3;
  localparam int TMO   = 15;
  localparam int NCONV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] ch_mask = 4'd0;
  logic       adc_eoc = 1'b0;
  logic [4:0] adc_data = 5'd0;
  logic       adc_start, adc_reset, result_valid, fault, busy;
  logic [1:0] mux_sel, result_ch;
  logic [6:0] result;

  logic       d0_rst = 1'b1;
  logic       d0_eoc = 1'b0;
  logic [4:0] d0_data = 5'd17;
  logic       d0_start, d0_areset, d0_rv, d0_fault, d0_busy;
  logic [1:0] d0_mux, d0_rch;
  logic [4:0] d0_res;

  always #5 clock = ~clock;

  sar_scan_ctrl #(.NCH(4), .RES(5), .OSR_LOG2(2), .SETTLE(3), .TIMEOUT(15)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .adc_eoc(adc_eoc), .adc_data(adc_data), .adc_start(adc_start),
    .adc_reset(adc_reset), .mux_sel(mux_sel), .result(result),
    .result_ch(result_ch), .result_valid(result_valid), .fault(fault), .busy(busy)
  );

  sar_scan_ctrl #(.NCH(4), .RES(5), .OSR_LOG2(0), .SETTLE(3), .TIMEOUT(15)) u_dut0 (
    .clock(clock), .reset(d0_rst), .enable(1'b1), .ch_mask(4'b1000),
    .adc_eoc(d0_eoc), .adc_data(d0_data), .adc_start(d0_start),
    .adc_reset(d0_areset), .mux_sel(d0_mux), .result(d0_res),
    .result_ch(d0_rch), .result_valid(d0_rv), .fault(d0_fault), .busy(d0_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scan model: a visit is a timeline of offsets d counted from the selection cycle
  bit m_act, m_emit, m_first, m_fault;
  int m_ch, m_d, m_park, m_sum, m_n, m_last, m_ptr, m_mux, m_res, m_rch;
  int cyc = 0, n_starts, n_parks, first_start_cyc, fault_cyc;
  int res_val[$], res_ch[$], res_cyc[$], res_st[$];
  bit bad_mux;
  bit core_run, alt;
  int core_cnt, mode;
  bit d0_run;
  int d0_cnt, d0_last = -1, d0_nres = 0;

  function automatic int pick(input logic [3:0] m, input int p, input bit incl);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (p + k + (incl ? 0 : 1)) % NCH;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        chk("rst_adc_reset", adc_reset, 1);
        chk("rst_adc_start", adc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_result", result, 0);
        chk("rst_result_ch", result_ch, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_fault", fault, 0);
        m_act = 0; m_first = 1; m_ptr = 0; m_mux = 0; m_res = 0; m_rch = 0; m_fault = 0;
        n_starts = 0; n_parks = 0; first_start_cyc = -1; fault_cyc = -1; bad_mux = 0;
        res_val.delete(); res_ch.delete(); res_cyc.delete(); res_st.delete();
        core_run = 0; adc_eoc = 0;
      end else begin
        chk("busy", busy, m_act);
        chk("adc_start", adc_start, m_act && m_d == S + 1 && (m_park == 0 || m_d < m_park));
        chk("adc_reset", adc_reset, m_act && m_park != 0 && m_d == m_park);
        chk("result_valid", result_valid, m_act && m_emit && m_d == m_park - 1);
        chk("mux_sel", mux_sel, m_mux);
        chk("result", result, m_res);
        chk("result_ch", result_ch, m_rch);
        chk("fault", fault, m_fault);
        if (adc_start) begin
          n_starts++;
          if (first_start_cyc < 0) first_start_cyc = cyc;
        end
        if (adc_reset) n_parks++;
        if (result_valid) begin
          res_val.push_back(int'(result)); res_ch.push_back(int'(result_ch));
          res_cyc.push_back(cyc); res_st.push_back(n_starts);
        end
        if (fault && fault_cyc < 0) fault_cyc = cyc;
        if (mux_sel == 2'd1 || mux_sel == 2'd3) bad_mux = 1;
        // Core: free-runs from start, one eoc every CORE_CONV_CYCLES until parked
        if (adc_reset) begin
          core_run = 0; adc_eoc = 0;
        end else if (adc_start) begin
          core_run = 1; core_cnt = 0; alt = 0; adc_eoc = 0;
        end else if (core_run && mode != 2) begin
          core_cnt++;
          adc_eoc = (core_cnt == CORE_CONV_CYCLES);
          if (adc_eoc) begin
            core_cnt = 0;
            case (mode)
              0:       adc_data = 5'd31;
              1:       begin adc_data = alt ? 5'd5 : 5'd3; alt = !alt; end
              default: adc_data = 5'($urandom_range(0, 31));
            endcase
          end else if (mode == 3) begin
            adc_data = 5'($urandom);
          end
        end else begin
          adc_eoc = 0;
        end
        if (!m_act) begin
          if (enable && ch_mask != 4'd0) begin
            m_ch = pick(ch_mask, m_ptr, m_first); m_first = 0; m_mux = m_ch;
            m_act = 1; m_d = 1; m_park = 0; m_emit = 0; m_sum = 0; m_n = 0; m_last = S + 1;
          end
        end else begin
          if (m_park == 0) begin
            if (!enable) m_park = m_d + 1;
            else if (m_d > S + 1) begin
              if (adc_eoc) begin
                m_sum += int'(adc_data); m_n++; m_last = m_d;
                if (m_n == NCONV) begin m_park = m_d + 3; m_emit = 1; end
              end else if (m_d - m_last == TMO - 1) begin
                m_fault = 1; m_park = m_d + 1;
              end
            end
          end
          if (m_emit && m_d == m_park - 2) begin m_res = m_sum; m_rch = m_ch; end
          if (m_d == m_park) begin m_act = 0; m_ptr = m_ch; end
          else m_d++;
        end
      end
      if (d0_rst) begin
        d0_eoc = 0; d0_run = 0;
      end else begin
        if (d0_busy) chk("d0_mux_sel", d0_mux, 3);
        if (d0_rv) begin
          chk("d0_result", d0_res, 17);
          chk("d0_result_ch", d0_rch, 3);
          if (d0_last >= 0) chk("d0_period", cyc - d0_last, 15);
          d0_last = cyc; d0_nres++;
        end
        if (d0_areset) begin d0_run = 0; d0_eoc = 0; end
        else if (d0_start) begin d0_run = 1; d0_cnt = 0; d0_eoc = 0; end
        else if (d0_run) begin
          d0_cnt++;
          d0_eoc = (d0_cnt == CORE_CONV_CYCLES);
          if (d0_eoc) d0_cnt = 0;
        end else d0_eoc = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #3; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("async_adc_reset", adc_reset, 1);
    chk("async_busy", busy, 0);
    chk("async_mux_sel", mux_sel, 0);
    chk("async_result_valid", result_valid, 0);
    chk("async_fault", fault, 0);
    tick(2);
    chk("held_adc_reset", adc_reset, 1);
    reset = 1'b0;
  endtask

  task automatic wait_res(input int n, input int lim);
    for (int k = 0; k < lim && res_val.size() < n; k++) tick(1);
    chk("wait_results", res_val.size() >= n, 1);
  endtask

  initial begin
    mode = 0;
    tick(3);
    chk("init_adc_reset", adc_reset, 1);
    chk("init_busy", busy, 0);
    chk("init_result", result, 0);
    reset = 1'b0; d0_rst = 1'b0;

    // Full mask, full-scale data: 4*31 = 124 per channel, visit = 1+3+1+28+3 clocks
    ch_mask = 4'b1111; mode = 0; enable = 1'b1;
    wait_res(5, 400);
    if (res_val.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("t1_result", res_val[i], 124);
        chk("t1_result_ch", res_ch[i], i % 4);
      end
      for (int i = 0; i < 4; i++) chk("t1_starts_per_ch", res_st[i], i + 1);
      chk("t1_period", res_cyc[1] - res_cyc[0], 36);
    end

    // Sparse mask, alternating 3/5: 3+5+3+5 = 16
    enable = 1'b0; do_reset();
    ch_mask = 4'b0101; mode = 1; enable = 1'b1;
    wait_res(3, 300);
    if (res_val.size() >= 3) begin
      chk("t2_result0", res_val[0], 16); chk("t2_ch0", res_ch[0], 0);
      chk("t2_result1", res_val[1], 16); chk("t2_ch1", res_ch[1], 2);
      chk("t2_result2", res_val[2], 16); chk("t2_ch2", res_ch[2], 0);
    end
    chk("t2_no_masked_mux", bad_mux, 0);

    // Dead core: timeout fault 15 cycles after start, park, move on
    enable = 1'b0; do_reset();
    ch_mask = 4'b1111; mode = 2; enable = 1'b1;
    for (int k = 0; k < 200 && fault_cyc < 0; k++) tick(1);
    chk("t3_fault_seen", fault_cyc >= 0, 1);
    chk("t3_fault_latency", fault_cyc - first_start_cyc, 15);
    chk("t3_one_park", n_parks, 1);
    chk("t3_no_result", res_val.size(), 0);
    tick(1);
    chk("t3_next_ch", mux_sel, 1);
    chk("t3_fault_sticky", fault, 1);

    // Abort during the second conversion of ch1
    enable = 1'b0; mode = 0; do_reset();
    ch_mask = 4'b1111; enable = 1'b1;
    for (int k = 0; k < 200 && n_starts < 2; k++) tick(1);
    chk("t4_second_start", n_starts, 2);
    tick(9);
    begin
      int p0;
      p0 = n_parks;
      enable = 1'b0;
      tick(2);
      chk("t4_one_park", n_parks - p0, 1);
    end
    chk("t4_no_ch1_result", res_val.size(), 1);
    tick(1);
    chk("t4_idle_after_park", busy, 0);
    enable = 1'b1;
    tick(2);
    chk("t4_resume_ch", mux_sel, 2);
    chk("t4_resume_busy", busy, 1);
    wait_res(2, 100);
    if (res_val.size() >= 2) begin
      chk("t4_resume_tag", res_ch[1], 2);
      chk("t4_resume_result", res_val[1], 124);
    end

    // Reset in WAIT, then restart from ch0
    for (int k = 0; k < 100 && n_starts < 3; k++) tick(1);
    tick(3);
    do_reset();
    wait_res(1, 100);
    if (res_val.size() >= 1) chk("t5_first_ch", res_ch[0], 0);

    // Randomized phase with mask churn, enable drops and a dead-core window
    mode = 3;
    for (int k = 0; k < 3000; k++) begin
      int r;
      tick(1);
      r = int'($urandom_range(0, 99));
      if (r < 3) ch_mask = 4'($urandom);
      if (r == 50) enable = !enable;
      mode = (k >= 1500 && k < 1560) ? 2 : 3;
    end
    chk("rand_results_seen", res_val.size() >= 5, 1);
    chk("d0_results_seen", d0_nres > 50, 1);
    chk("d0_no_fault", d0_fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
